// File: rtl/serial_link_pkg.sv
// Shared definitions for the clocked serial link (transmitter and receiver).
// Contents: frame FSM state type, line-level constants, default payload width.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    localparam logic LINK_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a configurable reset value and an optional
// rising-edge detector on the synchronized output.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_async  asynchronous input
//   o_sync   synchronized level
//   o_rise   one-cycle pulse on a synchronized 0->1 transition (0 when EDGE_EN=0)
module sync_edge #(
    parameter logic RESET_VAL = 1'b0,
    parameter bit   EDGE_EN   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

    generate
        if (EDGE_EN) begin : g_edge
            logic r_prev;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_prev <= RESET_VAL;
                end else begin
                    r_prev <= r_sync;
                end
            end

            assign o_rise = r_sync & ~r_prev;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/serial_receiver.sv
// Receive side of the clocked serial link. Synchronizes the transmitter clock
// and data, samples data on each line-clock rise and decodes
// start / DATA_BITS payload (LSB first) / stop frames.
// Ports:
//   i_clk, i_rst_n      system clock, asynchronous active-low reset
//   i_line_clk          transmitter output clock (asynchronous)
//   i_line_data         transmitter data, idle high
//   o_data_out          last correctly received payload
//   o_data_valid        one-cycle strobe, o_data_out updated in the same cycle
//   o_frame_error       one-cycle strobe, stop bit sampled low
//   o_timeout_error     one-cycle strobe, frame abandoned after a stall
//   o_busy              high while a frame is in progress
module serial_receiver
    import serial_link_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
    parameter int unsigned TIMEOUT   = 4000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_line_clk,
    input  logic                 i_line_data,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_data_valid,
    output logic                 o_frame_error,
    output logic                 o_timeout_error,
    output logic                 o_busy
);

    localparam int unsigned CNT_W   = $clog2(DATA_BITS);
    localparam int unsigned STALL_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);

    logic w_event;
    logic w_bit;
    logic w_unused_clk_level;
    logic w_unused_data_rise;
    logic w_stall_hit;

    state_t                 r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [STALL_W-1:0]     r_stall;

    // Both lines use identical synchronizers so the sampled bit stays aligned
    // with the detected clock edge.
    sync_edge #(
        .RESET_VAL (1'b0),
        .EDGE_EN   (1'b1)
    ) u_sync_clk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_line_clk),
        .o_sync  (w_unused_clk_level),
        .o_rise  (w_event)
    );

    sync_edge #(
        .RESET_VAL (LINK_IDLE),
        .EDGE_EN   (1'b0)
    ) u_sync_data (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_line_data),
        .o_sync  (w_bit),
        .o_rise  (w_unused_data_rise)
    );

    assign w_stall_hit = (r_stall == STALL_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_stall         <= '0;
            o_data_out      <= '0;
            o_data_valid    <= 1'b0;
            o_frame_error   <= 1'b0;
            o_timeout_error <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            o_data_valid    <= 1'b0;
            o_frame_error   <= 1'b0;
            o_timeout_error <= 1'b0;

            // Stall counter holds at the abandon point instead of wrapping.
            if (r_state == IDLE || w_event) begin
                r_stall <= '0;
            end else if (!w_stall_hit) begin
                r_stall <= r_stall + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_event && w_bit == START_BIT) begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                        o_busy    <= 1'b1;
                    end
                end
                DATA: begin
                    // A sample event on the abandon cycle takes priority.
                    if (w_event) begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= STOP;
                        end
                    end else if (w_stall_hit) begin
                        o_timeout_error <= 1'b1;
                        r_state         <= IDLE;
                        o_busy          <= 1'b0;
                    end
                end
                STOP: begin
                    if (w_event) begin
                        if (w_bit == STOP_BIT) begin
                            o_data_out   <= r_shift;
                            o_data_valid <= 1'b1;
                        end else begin
                            o_frame_error <= 1'b1;
                        end
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end else if (w_stall_hit) begin
                        o_timeout_error <= 1'b1;
                        r_state         <= IDLE;
                        o_busy          <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Randomized scoreboard bench for serial_receiver. The stimulus side drives
// whole frames on the line and queues the strobe each frame must produce
// (kind, payload, arrival cycle); a monitor pops and compares on every strobe.
module tb_serial_receiver;

    localparam int unsigned DW = 8;
    localparam int unsigned TO = 64;

    localparam int K_VALID   = 0;
    localparam int K_FRAME   = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_NONE    = -1;

    // Line clock rise at negedge cycle c is acted on by the DUT at edge c+3.
    localparam int unsigned LAT = 3;

    typedef struct {
        int          kind;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          line_clk = 1'b0;
    logic          line_data = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_error;
    logic          timeout_error;
    logic          busy;

    int unsigned   cyc = 0;
    int            checks = 0;
    int            errors = 0;
    exp_t          q[$];
    logic [7:0]    model_last = 8'h00;

    serial_receiver #(
        .DATA_BITS (DW),
        .TIMEOUT   (TO)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_line_clk      (line_clk),
        .i_line_data     (line_data),
        .o_data_out      (data_out),
        .o_data_valid    (data_valid),
        .o_frame_error   (frame_error),
        .o_timeout_error (timeout_error),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin : mon
            int   n;
            int   k;
            exp_t e;
            n = int'(data_valid) + int'(frame_error) + int'(timeout_error);
            if (n > 0) begin
                chk("one_strobe", n, 1);
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {data_valid, frame_error, timeout_error}, 0);
                end else begin
                    e = q.pop_front();
                    k = timeout_error ? K_TIMEOUT : (frame_error ? K_FRAME : K_VALID);
                    chk("strobe_kind", k, e.kind);
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("data_out", data_out, e.data);
                    chk("busy_at_strobe", busy, 0);
                end
            end
        end
    end

    // One line bit: data changes with the line clock fall, rise after `half`.
    // If kind >= 0, the strobe caused by this rise is queued before the rise.
    task automatic send_bit(input logic b, input int half, input int kind,
                            input logic [7:0] d, input int unsigned extra);
        line_data = b;
        repeat (half) @(negedge clk);
        if (kind >= 0) q.push_back('{kind, d, cyc + LAT + extra});
        line_clk = 1'b1;
        repeat (half) @(negedge clk);
        line_clk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb, input int half);
        send_bit(1'b0, half, K_NONE, 8'h00, 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], half, K_NONE, 8'h00, 0);
        if (stopb) begin
            model_last = d;
            send_bit(1'b1, half, K_VALID, d, 0);
        end else begin
            send_bit(1'b0, half, K_FRAME, model_last, 0);
        end
        line_data = 1'b1;
    endtask

    task automatic idle(input int n);
        line_data = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_valid"}, data_valid, 0);
        chk({tag, "_frame_err"}, frame_error, 0);
        chk({tag, "_timeout_err"}, timeout_error, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(5);

        // 0xA5 with a good stop bit
        send_frame(8'hA5, 1'b1, 16);
        idle(10);

        // back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1, 8);
        send_frame(8'hFF, 1'b1, 8);
        idle(10);

        // bad stop bit: frame error, data_out keeps 0xFF
        send_frame(8'h3C, 1'b0, 10);
        idle(10);

        // stall after 4 data bits: timeout TO cycles after the last event
        begin
            logic [7:0] d;
            d = 8'h6B;
            send_bit(1'b0, 8, K_NONE, 8'h00, 0);
            for (int i = 0; i < 3; i++) send_bit(d[i], 8, K_NONE, 8'h00, 0);
            send_bit(d[3], 8, K_TIMEOUT, model_last, TO);
        end
        idle(TO + 10);
        chk("busy_after_timeout", busy, 0);
        send_frame(8'h81, 1'b1, 12);
        idle(10);

        // reset during bit 5 of 0x5A
        begin
            logic [7:0] d;
            d = 8'h5A;
            send_bit(1'b0, 8, K_NONE, 8'h00, 0);
            for (int i = 0; i < 5; i++) send_bit(d[i], 8, K_NONE, 8'h00, 0);
        end
        line_data = 1'b1;
        rst_n = 1'b0;
        model_last = 8'h00;
        repeat (4) @(negedge clk);
        check_all_zero("midreset");
        rst_n = 1'b1;
        idle(6);
        send_frame(8'h12, 1'b1, 9);
        idle(10);

        // bit period equal to TIMEOUT: each event lands on the abandon cycle
        send_frame(8'hC3, 1'b1, TO / 2);
        idle(10);

        // randomized frames, gaps and bit periods
        for (int n = 0; n < 8; n++) begin
            logic [7:0] d;
            logic       s;
            int         h;
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            h = int'($urandom_range(4, 31));
            send_frame(d, s, h);
            idle(int'($urandom_range(0, 20)));
        end

        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        idle(TO + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
